// File: rtl/lenpack.sv
// lenpack: packs variable-length elements into output beats whose total
// length fits in one vector of BS blocks. A one-beat element buffer feeds
// a registered output stage; elements that do not fit stay in the buffer
// and are emitted on following beats, oldest first in lane 0.
module lenpack #(
  parameter int VLEN = 256,
  parameter int BSW  = 5,
  localparam int BS  = 1 << BSW,
  // log2(VLEN) - BSW + 1 bits of length: lengths stay strictly below BS
  localparam int WW  = $clog2(VLEN) - BSW + 1
) (
  input  logic           clk,
  input  logic           rst,
  // input beat
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BSW:0]   in_num,
  input  logic [WW-1:0]  in_len  [BS],
  input  logic [BSW-1:0] in_pos  [BS],
  // output beat
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BSW:0]   out_num,
  output logic [WW-1:0]  out_len  [BS],
  output logic [BSW-1:0] out_pos  [BS],
  output logic [BSW-1:0] out_psum [BS]
);

  // Prefix sums are kept wide enough that they never wrap inside the buffer.
  localparam int PW = BSW + WW;

  // The largest cumulative length an output beat may carry; out_psum is only
  // BSW bits wide and downstream treats a wrapped sum as an empty lane.
  localparam logic [PW-1:0] FIT_LIMIT = PW'(BS - 1);

  localparam logic [BSW:0]  CNT_MAX   = (BSW + 1)'(BS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WW-1:0]  buf_len_q  [BS];
  logic [WW-1:0]  buf_len_d  [BS];
  logic [BSW-1:0] buf_pos_q  [BS];
  logic [BSW-1:0] buf_pos_d  [BS];
  logic [BSW:0]   buf_cnt_q;
  logic [BSW:0]   buf_cnt_d;

  logic           out_valid_q;
  logic           out_valid_d;
  logic [BSW:0]   out_num_q;
  logic [BSW:0]   out_num_d;
  logic [WW-1:0]  out_len_q  [BS];
  logic [WW-1:0]  out_len_d  [BS];
  logic [BSW-1:0] out_pos_q  [BS];
  logic [BSW-1:0] out_pos_d  [BS];
  logic [BSW-1:0] out_psum_q [BS];
  logic [BSW-1:0] out_psum_d [BS];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [PW-1:0]  psum [BS];   // inclusive prefix of buf_len
  logic [BSW:0]   fit_cnt;     // elements of the buffer head that fit (k)
  logic [BSW:0]   in_cnt;      // in_num clamped to BS
  logic           load;        // output register takes a new beat
  logic           accept;      // input handshake
  logic           in_ready_c;

  // Prefix sum over the buffer and the number of leading elements that fit.
  always_comb begin
    logic [PW-1:0] acc;
    // NOTE: every variable written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    acc     = '0;
    fit_cnt = '0;
    for (int j = 0; j < BS; j++) begin
      acc     = acc + PW'(buf_len_q[j]);
      psum[j] = acc;
      // Sums are monotonic, so the last lane that still fits sets the count;
      // zero-length lanes after it keep fitting as long as the sum does.
      if (((BSW + 1)'(j) < buf_cnt_q) && (acc <= FIT_LIMIT)) begin
        fit_cnt = (BSW + 1)'(j + 1);
      end
    end
  end

  // Handshake decisions; in_ready depends on out_ready combinationally so a
  // fully fitting beat can be replaced in the same cycle it is emitted.
  always_comb begin
    in_cnt     = (in_num > CNT_MAX) ? CNT_MAX : in_num;
    load       = (buf_cnt_q != '0) && (!out_valid_q || out_ready);
    in_ready_c = !rst && ((buf_cnt_q == '0) || (load && (fit_cnt == buf_cnt_q)));
    accept     = in_valid && in_ready_c;
  end

  // Next buffer contents: a new beat wins over the shift of the emitted head.
  always_comb begin
    logic [BSW+1:0] src;
    src       = '0;
    buf_cnt_d = buf_cnt_q;
    for (int j = 0; j < BS; j++) begin
      buf_len_d[j] = buf_len_q[j];
      buf_pos_d[j] = buf_pos_q[j];
    end

    if (accept) begin
      buf_cnt_d = in_cnt;
      // Lanes beyond the element count are cleared so the buffer never holds
      // stale lengths that a later shift could move into view.
      for (int j = 0; j < BS; j++) begin
        if ((BSW + 1)'(j) < in_cnt) begin
          buf_len_d[j] = in_len[j];
          buf_pos_d[j] = in_pos[j];
        end else begin
          buf_len_d[j] = '0;
          buf_pos_d[j] = '0;
        end
      end
    end else if (load) begin
      buf_cnt_d = buf_cnt_q - fit_cnt;
      for (int j = 0; j < BS; j++) begin
        src = (BSW + 2)'(j) + (BSW + 2)'(fit_cnt);
        if (src < (BSW + 2)'(BS)) begin
          buf_len_d[j] = buf_len_q[src[BSW-1:0]];
          buf_pos_d[j] = buf_pos_q[src[BSW-1:0]];
        end else begin
          buf_len_d[j] = '0;
          buf_pos_d[j] = '0;
        end
      end
    end
  end

  // Next output beat: load the fitting head, otherwise retire a consumed beat.
  always_comb begin
    out_valid_d = out_valid_q;
    out_num_d   = out_num_q;
    for (int j = 0; j < BS; j++) begin
      out_len_d[j]  = out_len_q[j];
      out_pos_d[j]  = out_pos_q[j];
      out_psum_d[j] = out_psum_q[j];
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_num_d   = fit_cnt;
      for (int j = 0; j < BS; j++) begin
        if ((BSW + 1)'(j) < fit_cnt) begin
          out_len_d[j]  = buf_len_q[j];
          out_pos_d[j]  = buf_pos_q[j];
          out_psum_d[j] = psum[j][BSW-1:0];
        end else begin
          out_len_d[j]  = '0;
          out_pos_d[j]  = '0;
          out_psum_d[j] = '0;
        end
      end
    end else if (out_valid_q && out_ready) begin
      // Data lanes are left as they are; only the valid flag drops.
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Element buffer register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the values from before this edge.
    if (rst) begin
      buf_cnt_q <= '0;
      // NOTE: these lane arrays are small flop banks, not a RAM, and are cleared
      // on reset because the output lanes must read zero afterwards.
      for (int j = 0; j < BS; j++) begin
        buf_len_q[j] <= '0;
        buf_pos_q[j] <= '0;
      end
    end else begin
      buf_cnt_q <= buf_cnt_d;
      for (int j = 0; j < BS; j++) begin
        buf_len_q[j] <= buf_len_d[j];
        buf_pos_q[j] <= buf_pos_d[j];
      end
    end
  end

  // Output beat register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      for (int j = 0; j < BS; j++) begin
        out_len_q[j]  <= '0;
        out_pos_q[j]  <= '0;
        out_psum_q[j] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_num_q   <= out_num_d;
      for (int j = 0; j < BS; j++) begin
        out_len_q[j]  <= out_len_d[j];
        out_pos_q[j]  <= out_pos_d[j];
        out_psum_q[j] <= out_psum_d[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign out_len   = out_len_q;
  assign out_pos   = out_pos_q;
  assign out_psum  = out_psum_q;

endmodule
